// File: rtl/multiport_slot_queue.sv
// Unordered multi-port slot buffer: enqueues fill the lowest free slots and
// dequeues take the lowest-index slots that are both valid and requested.
module multiport_slot_queue #(
  parameter int Depth    = 8,
  parameter int EnqWidth = 2,
  parameter int SelWidth = 2,
  parameter int Width    = 16,
  localparam int PtrWidth = $clog2(Depth)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [EnqWidth-1:0]          enq_vld_i,
  input  logic [EnqWidth*Width-1:0]    enq_payload_i,
  output logic [EnqWidth-1:0]          enq_rdy_o,
  input  logic [Depth-1:0]             sel_req_i,
  output logic [SelWidth-1:0]          deq_vld_o,
  output logic [SelWidth*Width-1:0]    deq_payload_o,
  output logic [SelWidth*PtrWidth-1:0] deq_idx_o,
  input  logic [SelWidth-1:0]          deq_rdy_i,
  output logic [Depth-1:0]             entry_vld_o,
  output logic [PtrWidth:0]            count_o
);

  localparam int CntWidth = PtrWidth + 1;

  logic [Depth-1:0]                 entry_vld;
  logic [Width-1:0]                 payload [Depth];
  logic [PtrWidth:0]                count;
  logic [EnqWidth-1:0][Depth-1:0]   enq_mask;
  logic [SelWidth-1:0][Depth-1:0]   result_mask;
  logic [EnqWidth-1:0]              enq_fire;
  logic [SelWidth-1:0]              deq_fire;
  logic [Depth-1:0]                 set_mask;
  logic [Depth-1:0]                 clr_mask;
  logic [PtrWidth:0]                n_enq;
  logic [PtrWidth:0]                n_deq;

  // Static priority: port k gets the k-th lowest free slot of the registered state.
  always_comb begin : enq_select
    logic [Depth-1:0] avail;
    avail = ~entry_vld;
    for (int k = 0; k < EnqWidth; k++) begin
      enq_mask[k] = avail & (~avail + Depth'(1));
      avail       = avail & ~enq_mask[k];
    end
  end

  always_comb begin : deq_select
    logic [Depth-1:0] avail;
    avail = sel_req_i & entry_vld;
    for (int j = 0; j < SelWidth; j++) begin
      result_mask[j] = avail & (~avail + Depth'(1));
      avail          = avail & ~result_mask[j];
    end
  end

  always_comb begin
    for (int k = 0; k < EnqWidth; k++) begin
      enq_rdy_o[k] = |enq_mask[k];
    end
  end

  // Index and payload stay zero on idle ports.
  always_comb begin
    deq_vld_o     = '0;
    deq_idx_o     = '0;
    deq_payload_o = '0;
    for (int j = 0; j < SelWidth; j++) begin
      deq_vld_o[j] = |result_mask[j];
      for (int i = 0; i < Depth; i++) begin
        if (result_mask[j][i]) begin
          deq_idx_o[j*PtrWidth +: PtrWidth] |= PtrWidth'(i);
          deq_payload_o[j*Width +: Width]   |= payload[i];
        end
      end
    end
  end

  assign enq_fire = enq_vld_i & enq_rdy_o;
  assign deq_fire = deq_vld_o & deq_rdy_i;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    n_enq    = '0;
    n_deq    = '0;
    for (int k = 0; k < EnqWidth; k++) begin
      if (enq_fire[k]) set_mask = set_mask | enq_mask[k];
      n_enq = n_enq + CntWidth'(enq_fire[k]);
    end
    for (int j = 0; j < SelWidth; j++) begin
      if (deq_fire[j]) clr_mask = clr_mask | result_mask[j];
      n_deq = n_deq + CntWidth'(deq_fire[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      entry_vld <= '0;
      count     <= '0;
    end else begin
      entry_vld <= (entry_vld & ~clr_mask) | set_mask;
      count     <= count + n_enq - n_deq;
    end
  end

  // Payload storage is deliberately not reset; a slot is only read once valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) begin
      for (int k = 0; k < EnqWidth; k++) begin
        if (enq_fire[k] && enq_mask[k][i]) payload[i] <= enq_payload_i[k*Width +: Width];
      end
    end
  end

  assign entry_vld_o = entry_vld;
  assign count_o     = count;

  for (genvar k = 0; k < EnqWidth; k++) begin : g_enq_chk
    assert property (@(posedge clk) disable iff (rst) $onehot0(enq_mask[k]));
    for (genvar m = k + 1; m < EnqWidth; m++) begin : g_pair
      assert property (@(posedge clk) disable iff (rst) (enq_mask[k] & enq_mask[m]) == '0);
    end
  end

  for (genvar j = 0; j < SelWidth; j++) begin : g_deq_chk
    assert property (@(posedge clk) disable iff (rst) $onehot0(result_mask[j]));
    for (genvar m = j + 1; m < SelWidth; m++) begin : g_pair
      assert property (@(posedge clk) disable iff (rst) (result_mask[j] & result_mask[m]) == '0);
    end
  end

  assert property (@(posedge clk) disable iff (rst) $countones(entry_vld) == int'(count));
  assert property (@(posedge clk) disable iff (rst) (set_mask & entry_vld) == '0);

endmodule

// File: tb/tb_multiport_slot_queue.sv
// Self-checking bench for multiport_slot_queue: directed vector table, a reset
// dominance sequence, then randomized traffic against a slot-list reference model.
module tb_multiport_slot_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [1:0]  enq_vld_i;
  logic [31:0] enq_payload_i;
  logic [1:0]  enq_rdy_o;
  logic [7:0]  sel_req_i;
  logic [1:0]  deq_vld_o;
  logic [31:0] deq_payload_o;
  logic [5:0]  deq_idx_o;
  logic [1:0]  deq_rdy_i;
  logic [7:0]  entry_vld_o;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  multiport_slot_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .enq_vld_i     (enq_vld_i),
    .enq_payload_i (enq_payload_i),
    .enq_rdy_o     (enq_rdy_o),
    .sel_req_i     (sel_req_i),
    .deq_vld_o     (deq_vld_o),
    .deq_payload_o (deq_payload_o),
    .deq_idx_o     (deq_idx_o),
    .deq_rdy_i     (deq_rdy_i),
    .entry_vld_o   (entry_vld_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [1:0]  enq_vld;
    logic [15:0] p0, p1;
    logic [7:0]  sel;
    logic [1:0]  deq_rdy;
    logic [1:0]  e_enq_rdy, e_deq_vld;
    logic [2:0]  e_idx0, e_idx1;
    logic [15:0] e_pay0, e_pay1;
    logic [7:0]  e_entry;
    logic [3:0]  e_count;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic fl, logic [1:0] ev, logic [15:0] p0, logic [15:0] p1,
                              logic [7:0] sel, logic [1:0] dr, logic [1:0] er, logic [1:0] dv,
                              logic [2:0] i0, logic [2:0] i1, logic [15:0] q0, logic [15:0] q1,
                              logic [7:0] ent, logic [3:0] cnt);
    vec_t v;
    v.flush = fl; v.enq_vld = ev; v.p0 = p0; v.p1 = p1; v.sel = sel; v.deq_rdy = dr;
    v.e_enq_rdy = er; v.e_deq_vld = dv; v.e_idx0 = i0; v.e_idx1 = i1;
    v.e_pay0 = q0; v.e_pay1 = q1; v.e_entry = ent; v.e_count = cnt;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic fl, input logic [1:0] ev,
                               input logic [15:0] p0, input logic [15:0] p1,
                               input logic [7:0] sel, input logic [1:0] dr);
    rst           = r;
    flush_i       = fl;
    enq_vld_i     = ev;
    enq_payload_i = {p1, p0};
    sel_req_i     = sel;
    deq_rdy_i     = dr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] er, input logic [1:0] dv,
                          input logic [2:0] i0, input logic [2:0] i1,
                          input logic [15:0] q0, input logic [15:0] q1,
                          input logic [7:0] ent, input logic [3:0] cnt);
    checkOutput({tag, " enq_rdy"}, 32'(enq_rdy_o), 32'(er));
    checkOutput({tag, " deq_vld"}, 32'(deq_vld_o), 32'(dv));
    checkOutput({tag, " idx0"}, 32'(deq_idx_o[2:0]), 32'(i0));
    checkOutput({tag, " idx1"}, 32'(deq_idx_o[5:3]), 32'(i1));
    checkOutput({tag, " pay0"}, 32'(deq_payload_o[15:0]), 32'(q0));
    checkOutput({tag, " pay1"}, 32'(deq_payload_o[31:16]), 32'(q1));
    checkOutput({tag, " entry_vld"}, 32'(entry_vld_o), 32'(ent));
    checkOutput({tag, " count"}, 32'(count_o), 32'(cnt));
  endtask

  // Reference model: plain slot arrays, scanned in ascending order.
  logic        mv [8];
  logic [15:0] mp [8];

  initial begin
    vecs[0]  = mk(0, 2'b11, 16'hA0, 16'hA1, 8'h00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 2'b11, 16'hA2, 16'hA3, 8'h00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 8'h03, 2);
    vecs[2]  = mk(0, 2'b11, 16'hA4, 16'hA5, 8'h00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 8'h0F, 4);
    vecs[3]  = mk(0, 2'b11, 16'hA6, 16'hA7, 8'h00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 8'h3F, 6);
    vecs[4]  = mk(0, 2'b00, 16'h0,  16'h0,  8'h24, 2'b11, 2'b00, 2'b11, 2, 5, 16'hA2, 16'hA5, 8'hFF, 8);
    vecs[5]  = mk(0, 2'b11, 16'hB0, 16'hB1, 8'h01, 2'b01, 2'b11, 2'b01, 0, 0, 16'hA0, 0, 8'hDB, 6);
    vecs[6]  = mk(0, 2'b11, 16'hC0, 16'hC1, 8'h00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 8'hFE, 7);
    vecs[7]  = mk(0, 2'b00, 16'h0,  16'h0,  8'hFF, 2'b00, 2'b00, 2'b11, 0, 1, 16'hC0, 16'hA1, 8'hFF, 8);
    vecs[8]  = mk(1, 2'b11, 16'hE0, 16'hE1, 8'hFF, 2'b11, 2'b00, 2'b11, 0, 1, 16'hC0, 16'hA1, 8'hFF, 8);
    vecs[9]  = mk(0, 2'b01, 16'hD0, 16'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 8'h00, 0);
    vecs[10] = mk(0, 2'b00, 16'h0,  16'h0,  8'hFF, 2'b00, 2'b11, 2'b01, 0, 0, 16'hD0, 0, 8'h01, 1);
    vecs[11] = mk(1, 2'b11, 16'hE2, 16'hE3, 8'hFF, 2'b11, 2'b11, 2'b01, 0, 0, 16'hD0, 0, 8'h01, 1);
    vecs[12] = mk(0, 2'b10, 16'h0,  16'hF1, 8'h00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 8'h00, 0);
    vecs[13] = mk(0, 2'b00, 16'h0,  16'h0,  8'hFF, 2'b00, 2'b11, 2'b01, 1, 0, 16'hF1, 0, 8'h02, 1);

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      applyStimulus(0, vecs[r].flush, vecs[r].enq_vld, vecs[r].p0, vecs[r].p1,
                    vecs[r].sel, vecs[r].deq_rdy);
      #1;
      checkAll($sformatf("vec%0d", r), vecs[r].e_enq_rdy, vecs[r].e_deq_vld,
               vecs[r].e_idx0, vecs[r].e_idx1, vecs[r].e_pay0, vecs[r].e_pay1,
               vecs[r].e_entry, vecs[r].e_count);
    end

    // Reset must win over concurrent enqueue, dequeue and flush.
    @(negedge clk);
    applyStimulus(0, 0, 2'b11, 16'h11, 16'h22, 8'h00, 2'b00);
    @(negedge clk);
    applyStimulus(1, 1, 2'b11, 16'h33, 16'h44, 8'hFF, 2'b11);
    @(negedge clk);
    applyStimulus(0, 0, 2'b00, 0, 0, 8'hFF, 2'b00);
    #1;
    checkAll("rst_dom", 2'b11, 2'b00, 0, 0, 0, 0, 8'h00, 0);

    for (int i = 0; i < 8; i++) mv[i] = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        r, fl;
      logic [1:0]  ev, dr, er, dv;
      logic [15:0] p0, p1, q0, q1;
      logic [7:0]  sel, ent;
      logic [2:0]  i0, i1;
      logic [3:0]  cnt;
      int          free_slot[2];
      int          sel_slot[2];
      int          nfree, nsel;
      bit          fill_phase;

      fill_phase = ((cyc / 48) % 2) == 0;
      r   = ($urandom_range(0, 499) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      ev  = fill_phase ? 2'($urandom_range(0, 3) | $urandom_range(0, 3)) : 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      dr  = fill_phase ? 2'($urandom_range(0, 3) & $urandom_range(0, 3)) : 2'($urandom_range(0, 3) | $urandom_range(0, 3));
      p0  = 16'($urandom);
      p1  = 16'($urandom);
      sel = 8'($urandom);

      @(negedge clk);
      applyStimulus(r, fl, ev, p0, p1, sel, dr);
      #1;

      nfree = 0; nsel = 0; ent = '0; cnt = '0;
      free_slot[0] = 0; free_slot[1] = 0; sel_slot[0] = 0; sel_slot[1] = 0;
      for (int i = 0; i < 8; i++) begin
        if (!mv[i]) begin
          if (nfree < 2) free_slot[nfree] = i;
          nfree++;
        end else begin
          ent[i] = 1'b1;
          cnt++;
          if (sel[i]) begin
            if (nsel < 2) sel_slot[nsel] = i;
            nsel++;
          end
        end
      end
      er = {nfree > 1, nfree > 0};
      dv = {nsel > 1, nsel > 0};
      i0 = dv[0] ? 3'(sel_slot[0]) : 3'd0;
      i1 = dv[1] ? 3'(sel_slot[1]) : 3'd0;
      q0 = dv[0] ? mp[sel_slot[0]] : 16'h0;
      q1 = dv[1] ? mp[sel_slot[1]] : 16'h0;
      checkAll($sformatf("rnd%0d", cyc), er, dv, i0, i1, q0, q1, ent, cnt);

      if (r || fl) begin
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
      end else begin
        for (int j = 0; j < 2; j++)
          if (dv[j] && dr[j]) mv[sel_slot[j]] = 1'b0;
        if (ev[0] && er[0]) begin mv[free_slot[0]] = 1'b1; mp[free_slot[0]] = p0; end
        if (ev[1] && er[1]) begin mv[free_slot[1]] = 1'b1; mp[free_slot[1]] = p1; end
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
